// File: rtl/stream_rx_core_pkg.sv
// rtl/stream_rx_core_pkg.sv - shared constants and FSM encoding for stream_rx_core
package stream_rx_core_pkg;

    localparam logic [7:0] VERSION = 8'd1;

    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_CNT0    = 1;
    localparam int ADDR_CNT1    = 2;
    localparam int ADDR_CNT2    = 3;
    localparam int ADDR_STATUS  = 4;
    localparam int ADDR_FILL_LO = 5;
    localparam int ADDR_FILL_HI = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/stream_rx_fifo.sv
// rtl/stream_rx_fifo.sv - first-word-fall-through synchronous FIFO, 16-bit words
// Ports: clk; rst (sync, active-high); wr/wdata push side; rd/rdata/empty pop side;
//        full; fill = occupancy count (DEPTH_LOG2+1 bits)
module stream_rx_fifo
    import stream_rx_core_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic [15:0]         wdata,
    input  logic                rd,
    output logic [15:0]         rdata,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] fill
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [15:0]           mem [2**DEPTH_LOG2];
    logic [15:0]           head;
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2-1:0] rptr_nxt;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;
    logic                  load_bypass;
    logic                  load_mem;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH);
    assign fill     = count;
    assign rdata    = head;
    assign do_push  = wr & ~full;
    assign do_pop   = rd & ~empty;
    assign rptr_nxt = rptr + DEPTH_LOG2'(1);

    // head always mirrors mem[rptr]. When the incoming word becomes the head
    // (FIFO empty, or last word popping) it bypasses the RAM so it is visible
    // right after the push edge; otherwise the successor is fetched from RAM.
    assign load_bypass = do_push & (empty | ((count == CW'(1)) & do_pop));
    assign load_mem    = do_pop & (count > CW'(1));

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
        if (load_bypass) begin
            head <= wdata;
        end else if (load_mem) begin
            head <= mem[rptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rptr <= rptr_nxt;
            end
            if (do_push & ~do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop & ~do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/stream_rx_core.sv
// rtl/stream_rx_core.sv - host-to-device word stream receiver with FWFT buffer
// Ports: BUS_CLK, RST (sync, active-high); BUS_ADD/BUS_DATA_IN/BUS_WR/BUS_RD/BUS_DATA_OUT
//        register bus; STREAM_VALID/STREAM_DATA/STREAM_READY host stream;
//        FIFO_READ/FIFO_EMPTY/FIFO_DATA downstream pop interface
module stream_rx_core
    import stream_rx_core_pkg::*;
#(
    parameter int ABUSWIDTH  = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                 BUS_CLK,
    input  logic                 RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_WR,
    input  logic                 BUS_RD,
    input  logic                 STREAM_VALID,
    input  logic [15:0]          STREAM_DATA,
    output logic                 STREAM_READY,
    input  logic                 FIFO_READ,
    output logic                 FIFO_EMPTY,
    output logic [15:0]          FIFO_DATA
);

    localparam logic [ABUSWIDTH-1:0] A_CTRL    = ABUSWIDTH'(ADDR_CTRL);
    localparam logic [ABUSWIDTH-1:0] A_CNT0    = ABUSWIDTH'(ADDR_CNT0);
    localparam logic [ABUSWIDTH-1:0] A_CNT1    = ABUSWIDTH'(ADDR_CNT1);
    localparam logic [ABUSWIDTH-1:0] A_CNT2    = ABUSWIDTH'(ADDR_CNT2);
    localparam logic [ABUSWIDTH-1:0] A_STATUS  = ABUSWIDTH'(ADDR_STATUS);
    localparam logic [ABUSWIDTH-1:0] A_FILL_LO = ABUSWIDTH'(ADDR_FILL_LO);
    localparam logic [ABUSWIDTH-1:0] A_FILL_HI = ABUSWIDTH'(ADDR_FILL_HI);

    rx_state_t           state;
    logic                irst;
    logic [23:0]         rx_count;
    logic [23:0]         remaining;
    logic [7:0]          fill_buf;
    logic                wr_arm;
    logic                arm_s1;
    logic                arm_s2;
    logic                arm;
    logic                xfer;
    logic                fifo_full;
    logic [DEPTH_LOG2:0] fifo_fill;
    logic [15:0]         fill16;
    logic [7:0]          status;

    // A write to address 0 is a soft reset of everything except the read port.
    assign irst   = RST | (BUS_WR & (BUS_ADD == A_CTRL));
    assign wr_arm = BUS_WR & (BUS_ADD == A_CNT2);
    assign arm    = arm_s1 & ~arm_s2;

    assign STREAM_READY = (state == ST_RECV) & ~fifo_full;
    assign xfer         = STREAM_VALID & STREAM_READY;
    assign fill16       = 16'(fifo_fill);
    assign status       = {5'b0, fifo_full, state == ST_DONE, state == ST_RECV};

    stream_rx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk  (BUS_CLK),
        .rst  (irst),
        .wr   (xfer),
        .wdata(STREAM_DATA),
        .rd   (FIFO_READ),
        .rdata(FIFO_DATA),
        .empty(FIFO_EMPTY),
        .full (fifo_full),
        .fill (fifo_fill)
    );

    always_ff @(posedge BUS_CLK) begin
        if (irst) begin
            rx_count <= '0;
            fill_buf <= '0;
            arm_s1   <= 1'b0;
            arm_s2   <= 1'b0;
        end else begin
            arm_s1 <= wr_arm;
            arm_s2 <= arm_s1;
            if (BUS_WR) begin
                case (BUS_ADD)
                    A_CNT0:  rx_count[7:0]   <= BUS_DATA_IN;
                    A_CNT1:  rx_count[15:8]  <= BUS_DATA_IN;
                    A_CNT2:  rx_count[23:16] <= BUS_DATA_IN;
                    default: ;
                endcase
            end
            // Snapshot the high byte so a lo/hi read pair is coherent.
            if (BUS_RD && (BUS_ADD == A_FILL_LO)) begin
                fill_buf <= fill16[15:8];
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            BUS_DATA_OUT <= '0;
        end else if (BUS_RD) begin
            case (BUS_ADD)
                A_CTRL:    BUS_DATA_OUT <= VERSION;
                A_CNT0:    BUS_DATA_OUT <= rx_count[7:0];
                A_CNT1:    BUS_DATA_OUT <= rx_count[15:8];
                A_CNT2:    BUS_DATA_OUT <= rx_count[23:16];
                A_STATUS:  BUS_DATA_OUT <= status;
                A_FILL_LO: BUS_DATA_OUT <= fill16[7:0];
                A_FILL_HI: BUS_DATA_OUT <= fill_buf;
                default:   BUS_DATA_OUT <= '0;
            endcase
        end
    end

    // ARM outranks a simultaneous final transfer; that word is still pushed
    // by the FIFO since xfer only depends on current state.
    always_ff @(posedge BUS_CLK) begin
        if (irst) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else if (arm) begin
            if (rx_count != '0) begin
                remaining <= rx_count;
                state     <= ST_RECV;
            end else begin
                state <= ST_DONE;
            end
        end else if ((state == ST_RECV) && xfer) begin
            remaining <= remaining - 24'd1;
            if (remaining == 24'd1) begin
                state <= ST_DONE;
            end
        end
    end

endmodule

// File: tb/tb_stream_rx_core.sv
// tb/tb_stream_rx_core.sv - self-checking bench for stream_rx_core
module tb_stream_rx_core;

    logic        BUS_CLK;
    logic        RST;
    logic [15:0] BUS_ADD;
    logic [7:0]  BUS_DATA_IN;
    logic [7:0]  BUS_DATA_OUT;
    logic        BUS_WR;
    logic        BUS_RD;
    logic        STREAM_VALID;
    logic [15:0] STREAM_DATA;
    logic        STREAM_READY;
    logic        FIFO_READ;
    logic        FIFO_EMPTY;
    logic [15:0] FIFO_DATA;

    stream_rx_core #(
        .ABUSWIDTH (16),
        .DEPTH_LOG2(4)
    ) dut (
        .BUS_CLK     (BUS_CLK),
        .RST         (RST),
        .BUS_ADD     (BUS_ADD),
        .BUS_DATA_IN (BUS_DATA_IN),
        .BUS_DATA_OUT(BUS_DATA_OUT),
        .BUS_WR      (BUS_WR),
        .BUS_RD      (BUS_RD),
        .STREAM_VALID(STREAM_VALID),
        .STREAM_DATA (STREAM_DATA),
        .STREAM_READY(STREAM_READY),
        .FIFO_READ   (FIFO_READ),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .FIFO_DATA   (FIFO_DATA)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp;
    } reg_vec_t;

    localparam int NV = 18;
    reg_vec_t vecs [NV];

    logic [15:0] sb [$];
    logic [15:0] next_data;
    int          acc;
    int          pops;
    int          max_fill;
    int          n_err;
    int          n_checks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: model the transfer/pop that happens at the coming edge, then
    // advance to 1 time unit past it.
    task automatic tick;
        if (RST || (BUS_WR && BUS_ADD == 16'd0)) begin
            sb.delete();
        end else begin
            if (STREAM_VALID && STREAM_READY) begin
                sb.push_back(STREAM_DATA);
                acc++;
                next_data++;
            end
            if (FIFO_READ && !FIFO_EMPTY) begin
                pops++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no word", FIFO_DATA);
                end else begin
                    check("pop_data", 32'(FIFO_DATA), 32'(sb.pop_front()));
                end
            end
        end
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        BUS_ADD     = a;
        BUS_DATA_IN = d;
        BUS_WR      = 1'b1;
        tick;
        BUS_WR = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        BUS_ADD = a;
        BUS_RD  = 1'b1;
        tick;
        BUS_RD = 1'b0;
        check(name, 32'(BUS_DATA_OUT), 32'(exp));
    endtask

    task automatic arm(input logic [23:0] n);
        STREAM_VALID = 1'b0;
        FIFO_READ    = 1'b0;
        bus_write(16'd1, n[7:0]);
        bus_write(16'd2, n[15:8]);
        bus_write(16'd3, n[23:16]);
        tick;
        tick;
    endtask

    task automatic run(input int cycles, input logic v, input logic r, input logic mon);
        for (int i = 0; i < cycles; i++) begin
            STREAM_VALID = v;
            STREAM_DATA  = next_data;
            FIFO_READ    = r;
            if (mon) begin
                BUS_ADD = 16'd5;
                BUS_RD  = 1'b1;
            end
            tick;
            if (mon && int'(BUS_DATA_OUT) > max_fill) max_fill = int'(BUS_DATA_OUT);
        end
        STREAM_VALID = 1'b0;
        FIFO_READ    = 1'b0;
        BUS_RD       = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_err = 0; n_checks = 0; acc = 0; pops = 0; max_fill = 0;
        next_data = 16'h1000;
        RST = 1'b1; BUS_ADD = '0; BUS_DATA_IN = '0; BUS_WR = 1'b0; BUS_RD = 1'b0;
        STREAM_VALID = 1'b0; STREAM_DATA = '0; FIFO_READ = 1'b0;

        vecs[0]  = '{1'b0, 16'd0,   8'h00, 8'h01};
        vecs[1]  = '{1'b0, 16'd4,   8'h00, 8'h00};
        vecs[2]  = '{1'b0, 16'd5,   8'h00, 8'h00};
        vecs[3]  = '{1'b0, 16'd6,   8'h00, 8'h00};
        vecs[4]  = '{1'b0, 16'd1,   8'h00, 8'h00};
        vecs[5]  = '{1'b0, 16'd2,   8'h00, 8'h00};
        vecs[6]  = '{1'b0, 16'd3,   8'h00, 8'h00};
        vecs[7]  = '{1'b0, 16'd7,   8'h00, 8'h00};
        vecs[8]  = '{1'b1, 16'd1,   8'hA5, 8'h00};
        vecs[9]  = '{1'b1, 16'd2,   8'h5A, 8'h00};
        vecs[10] = '{1'b0, 16'd1,   8'h00, 8'hA5};
        vecs[11] = '{1'b0, 16'd2,   8'h00, 8'h5A};
        vecs[12] = '{1'b1, 16'd4,   8'hFF, 8'h00};
        vecs[13] = '{1'b0, 16'd4,   8'h00, 8'h00};
        vecs[14] = '{1'b1, 16'd6,   8'hFF, 8'h00};
        vecs[15] = '{1'b0, 16'd6,   8'h00, 8'h00};
        vecs[16] = '{1'b0, 16'd200, 8'h00, 8'h00};
        vecs[17] = '{1'b1, 16'd1,   8'h00, 8'h00};

        tick; tick; tick;
        RST = 1'b0;
        check("reset_bus_data_out", 32'(BUS_DATA_OUT), 32'h0);
        check("reset_ready", 32'(STREAM_READY), 32'h0);
        check("reset_empty", 32'(FIFO_EMPTY), 32'h1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else rd_check($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        bus_write(16'd2, 8'h00);

        // Five words, no pops.
        acc = 0; pops = 0;
        arm(24'd5);
        run(20, 1'b1, 1'b0, 1'b0);
        check("cnt5_accepted", 32'(acc), 32'd5);
        check("cnt5_ready_low", 32'(STREAM_READY), 32'h0);
        rd_check("cnt5_status", 16'd4, 8'h02);
        rd_check("cnt5_fill", 16'd5, 8'd5);
        run(5, 1'b0, 1'b1, 1'b0);
        check("cnt5_pops", 32'(pops), 32'd5);
        check("cnt5_empty", 32'(FIFO_EMPTY), 32'h1);

        // Fill to capacity with 20 requested.
        acc = 0; pops = 0;
        arm(24'd20);
        run(30, 1'b1, 1'b0, 1'b0);
        check("full_accepted", 32'(acc), 32'd16);
        check("full_ready_low", 32'(STREAM_READY), 32'h0);
        rd_check("full_status", 16'd4, 8'h05);
        rd_check("full_fill", 16'd5, 8'd16);
        rd_check("full_fill_hi", 16'd6, 8'd0);
        run(4, 1'b0, 1'b1, 1'b0);
        run(20, 1'b1, 1'b0, 1'b0);
        check("full_total_accepted", 32'(acc), 32'd20);
        rd_check("full_done_status", 16'd4, 8'h06);
        run(16, 1'b0, 1'b1, 1'b0);
        check("full_pops", 32'(pops), 32'd20);
        check("full_drained_empty", 32'(FIFO_EMPTY), 32'h1);

        // Continuous streaming, 1000 words at one per cycle.
        acc = 0; pops = 0; max_fill = 0;
        arm(24'd1000);
        run(1000, 1'b1, 1'b1, 1'b1);
        check("stream_throughput", 32'(acc), 32'd1000);
        check("stream_fill_le2", 32'(max_fill <= 2), 32'h1);
        run(3, 1'b0, 1'b1, 1'b0);
        check("stream_pops", 32'(pops), 32'd1000);
        check("stream_empty", 32'(FIFO_EMPTY), 32'h1);
        check("stream_sb_empty", 32'(sb.size()), 32'd0);

        // Zero count goes straight to DONE.
        acc = 0;
        bus_write(16'd0, 8'h00);
        rd_check("zero_idle_status", 16'd4, 8'h00);
        arm(24'd0);
        rd_check("zero_done_status", 16'd4, 8'h02);
        run(5, 1'b1, 1'b0, 1'b0);
        check("zero_accepted", 32'(acc), 32'd0);

        // Re-arm in RECV reloads the remaining count.
        acc = 0; pops = 0;
        arm(24'd5);
        run(2, 1'b1, 1'b0, 1'b0);
        arm(24'd3);
        run(10, 1'b1, 1'b0, 1'b0);
        check("rearm_accepted", 32'(acc), 32'd5);
        run(6, 1'b0, 1'b1, 1'b0);
        check("rearm_pops", 32'(pops), 32'd5);

        // Soft reset mid-transfer.
        acc = 0;
        arm(24'd10);
        run(7, 1'b1, 1'b0, 1'b0);
        check("sreset_pre_accepted", 32'(acc), 32'd7);
        STREAM_VALID = 1'b1;
        bus_write(16'd0, 8'h00);
        check("sreset_empty", 32'(FIFO_EMPTY), 32'h1);
        check("sreset_ready", 32'(STREAM_READY), 32'h0);
        rd_check("sreset_fill", 16'd5, 8'd0);
        rd_check("sreset_count", 16'd1, 8'd0);
        STREAM_VALID = 1'b0;
        run(5, 1'b1, 1'b0, 1'b0);
        check("sreset_no_accept", 32'(acc), 32'd7);

        acc = 0; pops = 0;
        arm(24'd3);
        run(10, 1'b1, 1'b0, 1'b0);
        check("rearm3_accepted", 32'(acc), 32'd3);
        run(5, 1'b0, 1'b1, 1'b0);
        check("rearm3_pops", 32'(pops), 32'd3);
        check("rearm3_empty", 32'(FIFO_EMPTY), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_rx_core.md
# stream_rx_core

Host-to-device counterpart of the USB stream output path. Accepts 16-bit words pushed by the host over a valid/ready stream (already synchronous to BUS_CLK), buffers them in an internal first-word-fall-through FIFO, and presents them to downstream logic through the standard FIFO_READ/FIFO_EMPTY/FIFO_DATA triple. The host arms a transfer by writing a 24-bit word count over the register bus. The block accepts exactly that many words, then stops asserting ready.

## Interface
Parameters:
- ABUSWIDTH, 16, bus address width
- DEPTH_LOG2, 10, FIFO depth is 2**DEPTH_LOG2 words; legal range 4..15

Ports:
- BUS_CLK  in  1  single clock for everything
- RST  in  1  reset, synchronous, active-high
- BUS_ADD  in  ABUSWIDTH  register address
- BUS_DATA_IN  in  8  write data
- BUS_DATA_OUT  out  8  read data, registered
- BUS_WR  in  1  write strobe
- BUS_RD  in  1  read strobe
- STREAM_VALID  in  1  host word valid
- STREAM_DATA  in  16  host word
- STREAM_READY  out  1  block accepts word this cycle
- FIFO_READ  in  1  downstream pop request
- FIFO_EMPTY  out  1  no word available
- FIFO_DATA  out  16  head word, meaningful only while FIFO_EMPTY=0

## Operation
- Internal reset IRST = RST | (BUS_WR & BUS_ADD==0). It clears the FIFO, the FSM, the count registers and the fill buffer.
- Register map:
  - Address 0: read returns VERSION=1; write performs soft reset.
  - Addresses 1/2/3: RX_COUNT[7:0]/[15:8]/[23:16], read/write.
  - Address 4, read: {5'b0, full, done, busy}.
  - Address 5, read: FILL[7:0]; this read also latches FILL[15:8] into FILL_BUF.
  - Address 6, read: FILL_BUF.
  - Any other address reads 0. Writes to addresses ≥4 are ignored.
- ARM is a one-cycle pulse on the rising edge of (BUS_WR & BUS_ADD==3), detected with a 2-stage flop. ARM therefore occurs 2 cycles after the write.
- FSM states:
  - IDLE:
    - ARM with RX_COUNT≠0: remaining←RX_COUNT, go to RECV.
    - ARM with RX_COUNT==0: go to DONE.
  - RECV:
    - STREAM_READY = !full.
    - xfer = STREAM_VALID & STREAM_READY. On xfer, push STREAM_DATA and decrement remaining.
    - xfer with remaining==1: go to DONE.
    - ARM in RECV: reload remaining←RX_COUNT and stay in RECV, or go to DONE if RX_COUNT==0. ARM takes precedence over a simultaneous final xfer; that word is still pushed.
  - DONE: STREAM_READY=0. ARM behaves as in IDLE.
- busy = (state==RECV); done = (state==DONE).
- FIFO behaviour:
  - Pop when FIFO_READ & !FIFO_EMPTY. FIFO_READ while empty is ignored.
  - Push and pop in the same cycle are both performed, and FILL is unchanged.
  - A push is never issued when full, because READY is gated by full; this holds even if a pop happens in the same cycle.
- FILL is a (DEPTH_LOG2+1)-bit occupancy count, zero-extended to 16 bits. full = FILL==2**DEPTH_LOG2. Read/write pointers wrap modulo depth.
- Words leave the FIFO in exactly the order they were accepted; none are dropped or duplicated.

## Timing
- Reset values:
  - Outputs: BUS_DATA_OUT=0, STREAM_READY=0, FIFO_EMPTY=1.
  - Internal: FSM=IDLE, remaining=0, RX_COUNT=0, FILL_BUF=0.
- BUS_DATA_OUT updates on the clock edge where BUS_RD=1 and holds otherwise, giving 1-cycle read latency.
- STREAM_READY is decoded from registered state only; there is no combinational path from STREAM_VALID or FIFO_READ.
- Push-to-visible latency: a word accepted at edge N gives FIFO_EMPTY=0 and valid FIFO_DATA after edge N (FWFT).
- After a pop at edge N, the next word or FIFO_EMPTY=1 is visible after edge N.
- Full throughput is one word per cycle in each direction.
- IRST mid-transfer: any words in the FIFO are discarded. STREAM_READY is 0 from the cycle after the reset edge, and the FSM needs a new ARM.

## Structure
- Shared package: VERSION, register address constants, FSM state encoding (IDLE=0, RECV=1, DONE=2).
- Sub-module stream_rx_fifo:
  - Parameter DEPTH_LOG2; FWFT synchronous FIFO.
  - Ports: clk, rst, wr, wdata, rd, rdata, empty, full, fill.
  - Inferred block RAM plus an output register with bypass.
- The top level holds the register file, ARM detect and FSM. Target size: about 200 lines.

## Test plan
- Reset, then read addresses 0 and 4: expect 0x01 and 0x00; STREAM_READY=0, FIFO_EMPTY=1.
- RX_COUNT=5, VALID held high with data 0x1000..0x1004, FIFO_READ=0:
  - exactly 5 words accepted, READY falls after the 5th;
  - address 4 reads 0x02, FILL=5;
  - popping 5 times yields 0x1000..0x1004 in order, then FIFO_EMPTY=1.
- DEPTH_LOG2=4, RX_COUNT=20, no pops:
  - READY drops after 16 words and address 4 reads 0x05;
  - after 4 pops, exactly 4 more words are accepted, then done.
- RX_COUNT=1000, continuous VALID and FIFO_READ:
  - 1000 words pass at one word/cycle with an incrementing data check;
  - FILL stays ≤2; pointers wrap and no word is lost.
- RX_COUNT=0 then ARM: state DONE immediately; no words are accepted.
- Soft reset (write to address 0) after 7 of 10 words: FIFO_EMPTY=1, READY=0, FILL=0.
- Re-arm with 3: exactly 3 new words are delivered.
